// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP row sequencer.
//   ROW_MAX   : maximum rows per pass (also the sum-FIFO depth)
//   AW        : row address width
//   row_cnt_t : row counter type, one bit wider than an address so a full
//               16-row pass can be represented without wrapping
//   state_t   : sequencer states
//   clamp_rows: limits a requested row count to ROW_MAX
package sfp_pkg;

    localparam int ROW_MAX = 16;
    localparam int AW      = 4;

    typedef logic [AW:0] row_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        SYNC,
        DIV,
        DRAIN,
        DONE
    } state_t;

    function automatic row_cnt_t clamp_rows(input row_cnt_t rows);
        if (rows > row_cnt_t'(ROW_MAX)) begin
            return row_cnt_t'(ROW_MAX);
        end
        return rows;
    endfunction

endpackage

// File: rtl/sfp_strobe_pipe.sv
// Two-stage strobe delay line shared by the accumulate and divide phases.
// Stage 1 lines the acc/div strobes up with psum data returning from memory.
// Stage 2 lines the output write up with the registered sfp_out.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_acc/i_div : strobes issued together with the memory read
//   i_addr      : row address of the read being issued
//   o_acc/o_div : strobes aligned with returned data (stage 1)
//   o_out_wr    : output write enable (stage 2, follows o_div)
//   o_out_addr  : row address for o_out_wr
module sfp_strobe_pipe
    import sfp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_acc,
    input  logic          i_div,
    input  logic [AW-1:0] i_addr,
    output logic          o_acc,
    output logic          o_div,
    output logic          o_out_wr,
    output logic [AW-1:0] o_out_addr
);

    logic          r_acc;
    logic          r_div;
    logic [AW-1:0] r_addr;
    logic          r_out_wr;
    logic [AW-1:0] r_out_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= 1'b0;
            r_div      <= 1'b0;
            r_addr     <= '0;
            r_out_wr   <= 1'b0;
            r_out_addr <= '0;
        end else begin
            r_acc    <= i_acc;
            r_div    <= i_div;
            r_out_wr <= r_div;
            // Addresses only advance with a real strobe so out_addr holds
            // the last written row between passes.
            if (i_acc || i_div) begin
                r_addr <= i_addr;
            end
            if (r_div) begin
                r_out_addr <= r_addr;
            end
        end
    end

    assign o_acc      = r_acc;
    assign o_div      = r_div;
    assign o_out_wr   = r_out_wr;
    assign o_out_addr = r_out_addr;

endmodule

// File: rtl/sfp_ctrl.sv
// Sequencer for one SFP row datapath: accumulate N psum rows, handshake
// with the peer core, then replay the rows to divide and write back.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : pass start pulse (only honoured in IDLE)
//   num_rows     : rows in the pass, clamped to ROW_MAX
//   busy, done   : pass in progress / one-cycle end-of-pass pulse
//   mem_rd/addr  : psum memory read (data returns one cycle later)
//   acc, div     : SFP row strobes aligned with returned data
//   fifo_ext_rd  : pops own-sum FIFO toward the peer (same cycle as div)
//   core_ready   : own sums complete; peer_ready is the peer's copy
//   out_wr/addr  : output memory write for the registered sfp_out
module sfp_ctrl
    import sfp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_rows,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic          acc,
    output logic          div,
    output logic          fifo_ext_rd,
    output logic          core_ready,
    input  logic          peer_ready,
    output logic          out_wr,
    output logic [AW-1:0] out_addr
);

    state_t   r_state, w_state_next;
    row_cnt_t r_cnt, w_cnt_next;
    row_cnt_t r_n, w_n_next;
    row_cnt_t w_n_clamped;
    row_cnt_t w_last_row;
    logic     w_last_issue;
    logic     w_acc;
    logic     w_div;
    logic     w_out_wr;
    logic [AW-1:0] w_out_addr;

    assign w_n_clamped  = clamp_rows(num_rows);
    assign w_last_row   = r_n - row_cnt_t'(1);
    assign w_last_issue = (r_cnt == w_last_row);

    sfp_strobe_pipe u_pipe (
        .clk        (clk),
        .reset      (reset),
        .i_acc      (r_state == ACC),
        .i_div      (r_state == DIV),
        .i_addr     (r_cnt[AW-1:0]),
        .o_acc      (w_acc),
        .o_div      (w_div),
        .o_out_wr   (w_out_wr),
        .o_out_addr (w_out_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_n     <= w_n_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_n_next     = r_n;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_n_next     = w_n_clamped;
                    w_cnt_next   = '0;
                    w_state_next = (w_n_clamped == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_last_issue) begin
                    w_cnt_next   = '0;
                    w_state_next = SYNC;
                end else begin
                    w_cnt_next = r_cnt + row_cnt_t'(1);
                end
            end
            SYNC: begin
                if (core_ready && peer_ready) begin
                    w_state_next = DIV;
                end
            end
            DIV: begin
                if (w_last_issue) begin
                    w_cnt_next   = '0;
                    w_state_next = DRAIN;
                end else begin
                    w_cnt_next = r_cnt + row_cnt_t'(1);
                end
            end
            DRAIN: begin
                // Finish only once the last row has been written back.
                if (w_out_wr && (w_out_addr == w_last_row[AW-1:0])) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign mem_rd      = (r_state == ACC) || (r_state == DIV);
    assign mem_addr    = r_cnt[AW-1:0];
    assign acc         = w_acc;
    assign div         = w_div;
    assign fifo_ext_rd = w_div;
    // Sums are only complete once the last accumulate has left the pipe.
    assign core_ready  = (r_state == SYNC) && !w_acc;
    assign out_wr      = w_out_wr;
    assign out_addr    = w_out_addr;

endmodule

// File: tb/tb_sfp_ctrl.sv
module tb_sfp_ctrl;
    import sfp_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_rows;
    logic          busy, done, mem_rd, acc, div, fifo_ext_rd, core_ready;
    logic          peer_ready;
    logic          out_wr;
    logic [AW-1:0] mem_addr, out_addr;

    sfp_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .acc         (acc),
        .div         (div),
        .fifo_ext_rd (fifo_ext_rd),
        .core_ready  (core_ready),
        .peer_ready  (peer_ready),
        .out_wr      (out_wr),
        .out_addr    (out_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t mem_q[$];
    ev_t wr_q[$];
    int  acc_q[$];
    int  div_q[$];
    int  cr_q[$];
    int  done_q[$];
    int  bf_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected pulse, got 1, expected 0 (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expected events whenever the DUT presents a strobe.
    logic prev_busy = 1'b0;
    logic prev_cr   = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        int  c;
        if (mem_rd) begin
            if (mem_q.size() == 0) unexpected("mem_rd");
            else begin
                ev = mem_q.pop_front();
                check_int("mem_rd cycle", cyc, ev.cyc);
                check_int("mem_addr", int'(mem_addr), ev.addr);
            end
        end
        if (acc) begin
            if (acc_q.size() == 0) unexpected("acc");
            else begin
                c = acc_q.pop_front();
                check_int("acc cycle", cyc, c);
            end
            check_int("acc/div overlap", int'(div), 0);
        end
        if (div) begin
            if (div_q.size() == 0) unexpected("div");
            else begin
                c = div_q.pop_front();
                check_int("div cycle", cyc, c);
            end
        end
        if (div || fifo_ext_rd) check_int("fifo_ext_rd vs div", int'(fifo_ext_rd), int'(div));
        if (out_wr) begin
            if (wr_q.size() == 0) unexpected("out_wr");
            else begin
                ev = wr_q.pop_front();
                check_int("out_wr cycle", cyc, ev.cyc);
                check_int("out_addr", int'(out_addr), ev.addr);
            end
        end
        if (done) begin
            if (done_q.size() == 0) unexpected("done");
            else begin
                c = done_q.pop_front();
                check_int("done cycle", cyc, c);
            end
        end
        if (core_ready && !prev_cr) begin
            if (cr_q.size() == 0) unexpected("core_ready");
            else begin
                c = cr_q.pop_front();
                check_int("core_ready cycle", cyc, c);
            end
        end
        if (!busy && prev_busy) begin
            if (bf_q.size() == 0) unexpected("busy fall");
            else begin
                c = bf_q.pop_front();
                check_int("busy fall cycle", cyc, c);
            end
        end
        prev_busy = busy;
        prev_cr   = core_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = (AW+1)'(n);
        tick();
        start    = 1'b0;
    endtask

    // Expected timeline of a complete pass started (start high) in cycle s.
    // p_rise < 0 means peer_ready is already high.
    task automatic expect_pass(input int s, input int n_in, input int p_rise, output int done_cyc);
        int n, c, d;
        n = (n_in > ROW_MAX) ? ROW_MAX : n_in;
        if (n == 0) begin
            done_q.push_back(s + 1);
            bf_q.push_back(s + 2);
            done_cyc = s + 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                mem_q.push_back('{s + 1 + i, i});
                acc_q.push_back(s + 2 + i);
            end
            c = s + n + 2;
            cr_q.push_back(c);
            d = (p_rise <= c) ? c + 1 : p_rise + 1;
            for (int i = 0; i < n; i++) begin
                mem_q.push_back('{d + i, i});
                div_q.push_back(d + 1 + i);
                wr_q.push_back('{d + 2 + i, i});
            end
            done_cyc = d + n + 2;
            done_q.push_back(done_cyc);
            bf_q.push_back(done_cyc + 1);
        end
    endtask

    task automatic check_empty(input string name);
        check_int({name, " leftover mem_rd"}, mem_q.size(), 0);
        check_int({name, " leftover acc"}, acc_q.size(), 0);
        check_int({name, " leftover div"}, div_q.size(), 0);
        check_int({name, " leftover out_wr"}, wr_q.size(), 0);
        check_int({name, " leftover done"}, done_q.size(), 0);
        check_int({name, " leftover core_ready"}, cr_q.size(), 0);
        check_int({name, " leftover busy fall"}, bf_q.size(), 0);
        $display("[TB] %s: done, %0d checks so far, %0d failed", name, tests, fails);
    endtask

    task automatic check_all_zero(input string name);
        check_int({name, " busy"}, int'(busy), 0);
        check_int({name, " done"}, int'(done), 0);
        check_int({name, " mem_rd"}, int'(mem_rd), 0);
        check_int({name, " mem_addr"}, int'(mem_addr), 0);
        check_int({name, " acc"}, int'(acc), 0);
        check_int({name, " div"}, int'(div), 0);
        check_int({name, " fifo_ext_rd"}, int'(fifo_ext_rd), 0);
        check_int({name, " core_ready"}, int'(core_ready), 0);
        check_int({name, " out_wr"}, int'(out_wr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, c, p, d, dc, dc2;
        reset      = 1'b1;
        start      = 1'b0;
        num_rows   = '0;
        peer_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_int("reset out_addr", int'(out_addr), 0);
        reset = 1'b0;
        tick();

        // Basic pass, n=2
        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 2, -1, dc);
        do_start(2);
        wait_until(dc + 5);
        check_empty("basic n=2");

        // Peer stall, n=4, peer low for 20 cycles after core_ready
        peer_ready = 1'b0;
        s = cyc + 1;
        wait_until(s);
        c = s + 4 + 2;
        p = c + 20;
        expect_pass(s, 4, p, dc);
        do_start(4);
        wait_until(p);
        peer_ready = 1'b1;
        wait_until(dc + 5);
        check_empty("peer stall n=4");

        // n=0
        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 0, -1, dc);
        do_start(0);
        wait_until(dc + 5);
        check_empty("n=0");

        // n=20 clamps to 16
        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 20, -1, dc);
        do_start(20);
        wait_until(dc + 5);
        check_empty("n=20 clamp");

        // Start while busy is ignored
        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 3, -1, dc);
        do_start(3);
        wait_until(s + 2);
        do_start(5);
        wait_until(dc + 5);
        check_empty("start while busy");

        // Reset during DIV after 2 of 8 rows issued
        s = cyc + 1;
        wait_until(s);
        for (int i = 0; i < 8; i++) begin
            mem_q.push_back('{s + 1 + i, i});
            acc_q.push_back(s + 2 + i);
        end
        cr_q.push_back(s + 10);
        d = s + 11;
        mem_q.push_back('{d, 0});
        mem_q.push_back('{d + 1, 1});
        div_q.push_back(d + 1);
        bf_q.push_back(d + 2);
        do_start(8);
        wait_until(d + 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after reset");
        tick();
        wait_until(d + 10);
        check_empty("reset in DIV");

        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 8, -1, dc);
        do_start(8);
        wait_until(dc + 5);
        check_empty("fresh n=8");

        // Back-to-back passes
        s = cyc + 1;
        wait_until(s);
        expect_pass(s, 3, -1, dc);
        s2 = dc + 1;
        expect_pass(s2, 5, -1, dc2);
        do_start(3);
        wait_until(s2);
        do_start(5);
        wait_until(dc2 + 5);
        check_empty("back-to-back");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
- Sequencer for one SFP (sum/normalise) row datapath in one core.
- Phase 1 (accumulate): streams N psum rows from the psum memory into the SFP row with `acc`.
- Handshake: synchronises with the peer core so both cores' sum FIFOs are filled.
- Phase 2 (divide): replays the same N rows with `div` and `fifo_ext_rd`, then writes normalised outputs back by row address.

Parameters:
- ROW_MAX, 16: maximum rows per pass; equals the sum-FIFO depth.
- AW, 4: row address width, clog2(ROW_MAX).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- num_rows  in  AW+1  rows in this pass; sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- mem_rd  out  1  psum memory read enable; data returns 1 cycle later on the SFP row's sfp_in.
- mem_addr  out  AW  psum memory row address.
- acc  out  1  SFP row accumulate strobe, aligned with returned data.
- div  out  1  SFP row divide strobe, aligned with returned data.
- fifo_ext_rd  out  1  pops the own-sum FIFO toward the peer core.
- core_ready  out  1  this core's sums are complete (SYNC handshake).
- peer_ready  in  1  peer core's core_ready.
- out_wr  out  1  output memory write enable for sfp_out.
- out_addr  out  AW  output memory row address.

Behaviour:
- Reset: state=IDLE and all counters 0. Every output resets to 0: busy, done, mem_rd, mem_addr, acc, div, fifo_ext_rd, core_ready, out_wr, out_addr.
- Reset mid-pass aborts the pass immediately. There is no done pulse and no further strobes.
- States: IDLE, ACC, SYNC, DIV, DRAIN, DONE.
- IDLE:
  - On start, latch n = min(num_rows, ROW_MAX).
  - n=0 goes to DONE; otherwise goes to ACC.
  - start while busy is ignored.
- ACC:
  - Each cycle: mem_rd=1, mem_addr=cnt, cnt++.
  - When cnt=n-1 is issued, clear cnt and go to SYNC.
- Pipeline:
  - acc = registered (mem_rd and state==ACC).
  - div = registered (mem_rd and state==DIV).
  - fifo_ext_rd = div in the same cycle.
- SYNC:
  - core_ready=1 only when the acc pipeline register is empty (combinational from state plus the pipe bit).
  - Go to DIV on the first cycle where core_ready and peer_ready are both high.
  - peer_ready outside SYNC is ignored.
  - Wait is unbounded; there is no timeout.
- DIV: identical address sweep to ACC (rows 0..n-1). After the last issue, go to DRAIN.
- Output write:
  - out_wr = registered div, because sfp_out is registered.
  - out_addr = div's row address delayed to match.
  - So out_wr for row r occurs 2 cycles after the mem_rd for row r.
- DRAIN: wait until out_wr fires for row n-1, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Strobe counts:
  - acc, div and fifo_ext_rd each pulse exactly n times per pass.
  - They are never asserted in the same cycle as each other, except div with fifo_ext_rd.
- Row limit: n never exceeds ROW_MAX, so sum-FIFO overflow is impossible. num_rows > ROW_MAX is clamped.
- Counters are AW+1 bits wide so n=16 does not wrap. mem_addr and out_addr use the low AW bits.

Decomposition:
- Shared package `sfp_pkg`:
  - state enum (IDLE..DONE);
  - ROW_MAX and AW constants;
  - row-count type, AW+1 bits.
- One natural sub-module, `sfp_strobe_pipe`:
  - the 2-stage delay line carrying {acc, div, addr} to {acc/div, out_wr, out_addr};
  - reused for both phases.
- Everything else lives in the sfp_ctrl FSM.

Test Plan:
- Basic pass, start at cycle 0 with num_rows=2, peer_ready tied 1:
  - mem_rd at cycles 1,2 (addr 0,1);
  - acc at 2,3;
  - core_ready at 4;
  - mem_rd at 5,6;
  - div and fifo_ext_rd at 6,7;
  - out_wr at 7,8 (addr 0,1);
  - done at 9; busy low from cycle 10.
- Peer stall, num_rows=4, peer_ready held 0 for 20 cycles after core_ready:
  - no div or mem_rd during the wait;
  - DIV starts the cycle after peer_ready rises;
  - exactly 4 div and 4 out_wr pulses.
- Boundaries:
  - num_rows=0: done one cycle after start; zero mem_rd/acc/div.
  - num_rows=20: clamped to 16, so addresses 0..15 in both phases and 16 out_wr.
- Start while busy: second start mid-ACC is ignored; pulse counts match the first pass only.
- Reset in DIV after 2 of 8 rows: all outputs 0 the next cycle, no done pulse. A fresh start then runs a complete 8-row pass.
- Back-to-back passes: start in the cycle after done gives a correct second pass; addresses restart at 0.
